// File: rtl/mul_unit_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply controller: bus widths,
// RV32M multiply funct3 codes and the controller state encoding.
package mul_unit_ctrl_pkg;

  localparam int DATA_BUS        = 32;
  localparam int DOUBLE_DATA_BUS = 2 * DATA_BUS;

  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADJ  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mul_unit_ctrl_multiplier.sv
// Combinational unsigned array multiplier (WIDTH x WIDTH -> 2*WIDTH).
// The output is forced to zero while mul_en is low.
module Multiplier #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               mul_en,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  logic [2*WIDTH-1:0] aWide;
  logic [2*WIDTH-1:0] bWide;

  assign aWide   = {{WIDTH{1'b0}}, a};
  assign bWide   = {{WIDTH{1'b0}}, b};
  assign product = mul_en ? (aWide * bWide) : '0;
  assign done    = mul_en;

endmodule

// File: rtl/mul_unit_ctrl.sv
// RV32M multiply controller: converts signed operands to magnitudes, runs the
// unsigned array over a fixed cycle, then sign-corrects and selects a word.
module mul_unit_ctrl
  import mul_unit_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_BUS,
  parameter int FUNCT_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [FUNCT_WIDTH-1:0] funct,
  input  logic [DATA_WIDTH-1:0]  op1,
  input  logic [DATA_WIDTH-1:0]  op2,
  input  logic                   flush,
  output logic                   busy,
  output logic                   stall_req,
  output logic                   result_valid,
  output logic [DATA_WIDTH-1:0]  result
);

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   mag1_q, mag1_d;
  logic [DATA_WIDTH-1:0]   mag2_q, mag2_d;
  logic                    neg_q, neg_d;
  logic                    hi_q, hi_d;
  logic [2*DATA_WIDTH-1:0] prod_q;
  logic [DATA_WIDTH-1:0]   result_q;

  logic                    signed1, signed2;
  logic                    neg1, neg2;
  logic                    accept;
  logic [2*DATA_WIDTH-1:0] product;
  logic [2*DATA_WIDTH-1:0] adjusted;
  logic                    unusedMulDone;

  // -2^31 negates to 0x80000000, which is exactly its magnitude as unsigned.
  assign signed1 = (funct == FUNCT_WIDTH'(MULH_F3)) || (funct == FUNCT_WIDTH'(MULHSU_F3));
  assign signed2 = (funct == FUNCT_WIDTH'(MULH_F3));
  assign neg1    = signed1 && op1[DATA_WIDTH-1];
  assign neg2    = signed2 && op2[DATA_WIDTH-1];
  assign mag1_d  = neg1 ? (~op1 + 1'b1) : op1;
  assign mag2_d  = neg2 ? (~op2 + 1'b1) : op2;
  assign neg_d   = neg1 ^ neg2;
  assign hi_d    = (funct != FUNCT_WIDTH'(MUL_F3));

  assign accept  = (state_q == S_IDLE) && start && !funct[FUNCT_WIDTH-1] && !flush;

  Multiplier #(
    .WIDTH(DATA_WIDTH)
  ) uMultiplier (
    .a      (mag1_q),
    .b      (mag2_q),
    .mul_en (state_q == S_MUL),
    .product(product),
    .done   (unusedMulDone)
  );

  assign adjusted = neg_q ? (~prod_q + 1'b1) : prod_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mag1_q   <= '0;
      mag2_q   <= '0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            mag1_q  <= mag1_d;
            mag2_q  <= mag2_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            prod_q  <= product;
            state_q <= S_ADJ;
          end
        end
        S_ADJ: begin
          // A flush here leaves the previously returned result untouched.
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= hi_q ? adjusted[2*DATA_WIDTH-1:DATA_WIDTH]
                             : adjusted[DATA_WIDTH-1:0];
            state_q  <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE) && !flush;
  assign stall_req    = (start && (state_q == S_IDLE) && !funct[FUNCT_WIDTH-1])
                      || (state_q == S_MUL) || (state_q == S_ADJ);
  assign result       = result_q;

endmodule

// File: tb/tb_mul_unit_ctrl.sv
// Self-checking bench for mul_unit_ctrl: directed handshake cases plus random
// multiplies scored against an arithmetic reference model.
module tb_mul_unit_ctrl;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic        result_valid;
  logic [31:0] result;

  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t expQ[$];

  mul_unit_ctrl #(
    .DATA_WIDTH (32),
    .FUNCT_WIDTH(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .funct       (funct),
    .op1         (op1),
    .op2         (op2),
    .flush       (flush),
    .busy        (busy),
    .stall_req   (stall_req),
    .result_valid(result_valid),
    .result      (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference: full-precision product under the operand interpretation of each funct3.
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    case (f)
      3'b001:  p = sa * sb;
      3'b010:  p = sa * ub;
      default: p = {32'b0, a} * {32'b0, b};
    endcase
    return (f == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Called just after a rising edge with the DUT idle; returns just after the accepting edge.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input bit expectResult);
    exp_t e;
    start = 1'b1;
    funct = f;
    op1   = a;
    op2   = b;
    if (expectResult && !f[2]) begin
      e.res = refModel(f, a, b);
      e.due = cycle + 3;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) begin
        idle = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!idle) begin
      checks++;
      failures++;
      $display("[TB] FAIL waitIdle: busy still %0b after 20 cycles", busy);
    end
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (result_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpectedValid: result_valid=1 result=0x%0h with no request pending",
                 result);
      end else begin
        e = expQ.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("latency", cycle, e.due);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;

    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    funct = 3'b000;
    op1   = '0;
    op2   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetValid", result_valid, 0);
    checkOutput("resetResult", result, 0);
    checkOutput("resetStall", stall_req, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic MUL with a cycle-by-cycle handshake walk and a start during MUL.
    start = 1'b1;
    funct = 3'b000;
    #1;
    checkOutput("stallIdleStart", stall_req, 1);
    applyStimulus(3'b000, 32'd7, 32'd6, 1'b1);
    checkOutput("busyMul", busy, 1);
    checkOutput("stallMul", stall_req, 1);
    start = 1'b1;
    op1   = 32'd100;
    op2   = 32'd100;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busyAdj", busy, 1);
    checkOutput("stallAdj", stall_req, 1);
    @(posedge clk);
    #1;
    checkOutput("busyDone", busy, 1);
    checkOutput("stallDone", stall_req, 0);
    checkOutput("validDone", result_valid, 1);
    @(posedge clk);
    #1;
    checkOutput("busyBackIdle", busy, 0);
    checkOutput("validBackIdle", result_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resultHeld", result, 32'h0000_002A);

    applyStimulus(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b1);
    waitIdle();
    checkOutput("mulhMinSquare", result, 32'h4000_0000);
    applyStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    waitIdle();
    checkOutput("mulhsuMixed", result, 32'hFFFF_FFFF);
    applyStimulus(3'b000, 32'hFFFF_FFFE, 32'd3, 1'b1);
    waitIdle();
    checkOutput("mulNegative", result, 32'hFFFF_FFFA);
    applyStimulus(3'b001, 32'h0, 32'hFFFF_FFFF, 1'b1);
    waitIdle();
    checkOutput("zeroNeg", result, 32'h0);
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    waitIdle();
    checkOutput("mulhuMax", result, 32'hFFFF_FFFE);

    // Flush in ADJ: no pulse, back to idle, previous result kept.
    applyStimulus(3'b000, 32'd5, 32'd5, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flushAdjBusy", busy, 0);
    checkOutput("flushAdjResult", result, 32'hFFFF_FFFE);
    checkOutput("flushAdjValid", result_valid, 0);

    // Flush in DONE: pulse masked, but the word written in ADJ remains.
    applyStimulus(3'b000, 32'd5, 32'd5, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    checkOutput("flushDoneValid", result_valid, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flushDoneBusy", busy, 0);
    checkOutput("flushDoneResult", result, 32'd25);

    // Reset while in MUL.
    applyStimulus(3'b000, 32'd9, 32'd9, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rstMulBusy", busy, 0);
    checkOutput("rstMulResult", result, 0);
    checkOutput("rstMulValid", result_valid, 0);

    // Non-multiply funct is ignored.
    start = 1'b1;
    funct = 3'b100;
    op1   = 32'd3;
    op2   = 32'd4;
    #1;
    checkOutput("nonMulStall", stall_req, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("nonMulBusy", busy, 0);

    // Flush and start together in IDLE: request dropped.
    start = 1'b1;
    flush = 1'b1;
    funct = 3'b000;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    checkOutput("flushStartBusy", busy, 0);

    for (int n = 0; n < 60; n++) begin
      f = 3'($urandom_range(0, 7));
      a = pickOperand();
      b = pickOperand();
      waitIdle();
      applyStimulus(f, a, b, 1'b1);
      if (f[2]) checkOutput("randNonMulBusy", busy, 0);
    end

    waitIdle();
    repeat (6) @(posedge clk);
    #1;
    checkOutput("queueEmpty", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
